thread_issue_sched: RTL and testbench

- Schedules up to NUM_THREADS thread contexts onto the single shared execute stage (ADD/SUB/DIV/MUL step unit, fixed latency EXEC_LAT).
- Each cycle it picks at most one eligible thread by round-robin and presents that thread's id and instruction index (PC).
- It advances per-thread PCs, enforces the execute latency per thread, and signals completion when every enabled thread has reached prog_len.

---
 rtl/thread_issue_sched_pkg.sv | 16 +
 rtl/thread_issue_sched_rr_pick.sv | 32 +++
 rtl/thread_issue_sched.sv | 119 +++++++++++
 tb/tb_thread_issue_sched.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/thread_issue_sched_pkg.sv
// Shared types for the thread issue scheduler: FSM states, thread-id and PC types.
package thread_issue_sched_pkg;

  localparam int DEF_NUM_THREADS = 4;
  localparam int DEF_PC_W        = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  typedef logic [$clog2(DEF_NUM_THREADS)-1:0] tid_t;
  typedef logic [DEF_PC_W-1:0]                pc_t;

endpackage

// File: rtl/thread_issue_sched_rr_pick.sv
// Combinational round-robin finder: first set bit of eligible at or above rr_ptr, wrapping.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         eligible,
  input  logic [$clog2(N)-1:0] rr_ptr,
  output logic                 found,
  output logic [$clog2(N)-1:0] tid
);

  localparam int TW = $clog2(N);

  logic [2*N-1:0] rot;

  assign rot = {eligible, eligible} >> rr_ptr;

  always_comb begin
    int sum;
    found = |eligible;
    tid   = '0;
    sum   = 0;
    // Descending scan so the lowest offset from rr_ptr wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = int'(rr_ptr) + k;
        if (sum >= N) sum = sum - N;
        tid = TW'(sum);
      end
    end
  end

endmodule

// File: rtl/thread_issue_sched.sv
// Round-robin issue of per-thread instruction indices onto one shared execute stage,
// with a per-thread in-flight counter enforcing EXEC_LAT between issues of a thread.
module thread_issue_sched
  import thread_issue_sched_pkg::*;
#(
  parameter int NUM_THREADS = DEF_NUM_THREADS,
  parameter int PC_W        = DEF_PC_W,
  parameter int EXEC_LAT    = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [NUM_THREADS-1:0]         run_mask,
  input  logic [PC_W-1:0]                prog_len,
  input  logic                           stall,
  input  logic                           abort,
  output logic                           issue_valid,
  output logic [$clog2(NUM_THREADS)-1:0] issue_tid,
  output logic [PC_W-1:0]                issue_pc,
  output logic                           busy,
  output logic                           done,
  output logic [NUM_THREADS*PC_W-1:0]    thread_pc
);

  localparam int TW = $clog2(NUM_THREADS);
  localparam int CW = $clog2(EXEC_LAT + 1);

  sched_state_t           state;
  logic [PC_W-1:0]        pc       [NUM_THREADS];
  logic [CW-1:0]          inflight [NUM_THREADS];
  logic [NUM_THREADS-1:0] mask_q;
  logic [PC_W-1:0]        len_q;
  logic [TW-1:0]          rr_ptr;

  logic [NUM_THREADS-1:0] eligible;
  logic                   all_done;
  logic                   pick_found;
  logic [TW-1:0]          pick_tid;
  logic [TW-1:0]          rr_next;

  always_comb begin
    eligible = '0;
    all_done = 1'b1;
    for (int i = 0; i < NUM_THREADS; i++) begin
      eligible[i] = mask_q[i] && (pc[i] < len_q) && (inflight[i] == '0);
      if ((mask_q[i] && (pc[i] != len_q)) || (inflight[i] != '0)) all_done = 1'b0;
    end
  end

  rr_pick #(.N(NUM_THREADS)) u_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .found    (pick_found),
    .tid      (pick_tid)
  );

  always_comb begin
    if (int'(pick_tid) == NUM_THREADS - 1) rr_next = '0;
    else                                   rr_next = pick_tid + TW'(1);
  end

  assign issue_valid = (state == RUN) && !stall && !abort && pick_found;
  assign issue_tid   = pick_tid;
  assign issue_pc    = pc[pick_tid];
  assign busy        = (state == RUN);
  assign done        = (state == DONE);

  always_comb begin
    thread_pc = '0;
    for (int i = 0; i < NUM_THREADS; i++) thread_pc[i*PC_W +: PC_W] = pc[i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      mask_q <= '0;
      len_q  <= '0;
      rr_ptr <= '0;
      for (int i = 0; i < NUM_THREADS; i++) begin
        pc[i]       <= '0;
        inflight[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            mask_q <= run_mask;
            len_q  <= prog_len;
            rr_ptr <= '0;
            for (int i = 0; i < NUM_THREADS; i++) begin
              pc[i]       <= '0;
              inflight[i] <= '0;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            // Counters age every RUN cycle, stalled or not.
            for (int i = 0; i < NUM_THREADS; i++) begin
              if (inflight[i] != '0) inflight[i] <= inflight[i] - CW'(1);
            end
            if (issue_valid) begin
              pc[pick_tid]       <= pc[pick_tid] + PC_W'(1);
              inflight[pick_tid] <= CW'(EXEC_LAT - 1);
              rr_ptr             <= rr_next;
            end
            if (all_done) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_thread_issue_sched.sv
// Randomized bench for thread_issue_sched (EXEC_LAT 1 and 3 instances) and rr_pick.
module tb_thread_issue_sched;

  logic       clk = 1'b0;
  logic       rst_n, start_a, start_b, stall, abort;
  logic [3:0] run_mask;
  logic [7:0] prog_len;

  logic        a_valid, a_busy, a_done, b_valid, b_busy, b_done;
  logic [1:0]  a_tid, b_tid;
  logic [7:0]  a_pc, b_pc;
  logic [31:0] a_tp, b_tp;

  logic [3:0] rp_el;
  logic [1:0] rp_ptr, rp_tid;
  logic       rp_found;

  int checks = 0;
  int errors = 0;
  int iss_q[$];

  always #5 clk = ~clk;

  thread_issue_sched #(.NUM_THREADS(4), .PC_W(8), .EXEC_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .run_mask(run_mask), .prog_len(prog_len),
    .stall(stall), .abort(abort), .issue_valid(a_valid), .issue_tid(a_tid), .issue_pc(a_pc),
    .busy(a_busy), .done(a_done), .thread_pc(a_tp));

  thread_issue_sched #(.NUM_THREADS(4), .PC_W(8), .EXEC_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .run_mask(run_mask), .prog_len(prog_len),
    .stall(stall), .abort(abort), .issue_valid(b_valid), .issue_tid(b_tid), .issue_pc(b_pc),
    .busy(b_busy), .done(b_done), .thread_pc(b_tp));

  rr_pick #(.N(4)) u_rp (.eligible(rp_el), .rr_ptr(rp_ptr), .found(rp_found), .tid(rp_tid));

  task automatic test_reset();
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; stall = 1'b0; abort = 1'b0;
    run_mask = '0; prog_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a_valid, a_busy, a_done, b_valid, b_busy, b_done} !== 6'b0 || a_tp !== 32'h0 || b_tp !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: a v/b/d=%b%b%b tp=%h b v/b/d=%b%b%b tp=%h, required all 0",
               a_valid, a_busy, a_done, a_tp, b_valid, b_busy, b_done, b_tp);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  // One complete run checked cycle by cycle against a cycle-count model:
  // a thread is free again EXEC_LAT cycles after it issued.
  task automatic test_program(input int sel, input logic [3:0] mask, input int len,
                              input int st_lo, input int st_hi, input int abort_after);
    int m_pc[4];
    int m_ready[4];
    int ptr, issues, exp_tid, lat, idx, cyc;
    bit found, exp_valid, fin, ended, aborted;
    logic o_valid, o_busy, o_done;
    logic [1:0] o_tid;
    logic [7:0] o_pc;
    logic [31:0] o_tp, exp_tp;
    lat = sel ? 3 : 1;
    @(posedge clk); #1;
    run_mask = mask; prog_len = len[7:0];
    if (sel != 0) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    for (int i = 0; i < 4; i++) begin m_pc[i] = 0; m_ready[i] = 0; end
    ptr = 0; issues = 0; ended = 0; aborted = 0; cyc = 0;
    iss_q.delete();
    while (!ended && cyc < 4000) begin
      stall = (cyc >= st_lo && cyc <= st_hi);
      abort = (abort_after >= 0 && issues == abort_after);
      found = 0; exp_tid = 0;
      for (int k = 0; k < 4; k++) begin
        idx = (ptr + k) % 4;
        if (!found && mask[idx] && m_pc[idx] < len && cyc >= m_ready[idx]) begin
          found = 1; exp_tid = idx;
        end
      end
      exp_valid = found && !stall && !abort;
      fin = 1;
      for (int i = 0; i < 4; i++)
        if ((mask[i] && m_pc[i] != len) || cyc < m_ready[i]) fin = 0;
      exp_tp = {m_pc[3][7:0], m_pc[2][7:0], m_pc[1][7:0], m_pc[0][7:0]};
      @(negedge clk);
      o_valid = sel ? b_valid : a_valid; o_busy = sel ? b_busy : a_busy;
      o_done = sel ? b_done : a_done;    o_tid = sel ? b_tid : a_tid;
      o_pc = sel ? b_pc : a_pc;          o_tp = sel ? b_tp : a_tp;
      checks++;
      if (o_busy !== 1'b1 || o_done !== 1'b0) begin
        errors++;
        $display("FAIL run_state cyc=%0d: busy=%b done=%b, required 1/0", cyc, o_busy, o_done);
      end
      checks++;
      if (o_valid !== exp_valid) begin
        errors++;
        $display("FAIL issue_valid lat=%0d cyc=%0d: got %b required %b", lat, cyc, o_valid, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (o_tid !== exp_tid[1:0] || o_pc !== m_pc[exp_tid][7:0]) begin
          errors++;
          $display("FAIL issue_tid_pc lat=%0d cyc=%0d: got (%0d,%0d) required (%0d,%0d)",
                   lat, cyc, o_tid, o_pc, exp_tid, m_pc[exp_tid]);
        end
      end
      checks++;
      if (o_tp !== exp_tp) begin
        errors++;
        $display("FAIL thread_pc cyc=%0d: got %h required %h", cyc, o_tp, exp_tp);
      end
      @(posedge clk); #1;
      if (abort) begin
        aborted = 1; ended = 1;
      end else begin
        if (exp_valid) begin
          iss_q.push_back(exp_tid * 256 + m_pc[exp_tid]);
          m_pc[exp_tid]++;
          m_ready[exp_tid] = cyc + lat;
          ptr = (exp_tid + 1) % 4;
          issues++;
        end
        if (fin) ended = 1;
      end
      cyc++;
    end
    stall = 1'b0; abort = 1'b0;
    checks++;
    if (!ended) begin
      errors++;
      $display("FAIL run_timeout: no completion after %0d cycles", cyc);
    end
    @(negedge clk);
    o_busy = sel ? b_busy : a_busy; o_done = sel ? b_done : a_done;
    checks++;
    if (o_busy !== 1'b0 || o_done !== !aborted) begin
      errors++;
      $display("FAIL end_cycle aborted=%0d: busy=%b done=%b, required 0/%0d", aborted, o_busy, o_done, !aborted);
    end
    @(negedge clk);
    o_busy = sel ? b_busy : a_busy; o_done = sel ? b_done : a_done;
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL after_end: busy=%b done=%b, required 0/0", o_busy, o_done);
    end
    if (!aborted) begin
      checks++;
      if (issues != $countones(mask) * len) begin
        errors++;
        $display("FAIL issue_count: got %0d required %0d", issues, $countones(mask) * len);
      end
    end
  endtask

  task automatic test_basic();
    int exp_seq[8] = '{0, 256, 512, 768, 1, 257, 513, 769};
    test_program(0, 4'b1111, 2, -1, -1, -1);
    checks++;
    if (iss_q.size() != 8 || iss_q[0] != exp_seq[0] || iss_q[3] != exp_seq[3] ||
        iss_q[4] != exp_seq[4] || iss_q[7] != exp_seq[7]) begin
      errors++;
      $display("FAIL basic_sequence: got %0d issues first=%0h, required 8 issues (0,0)..(3,1)",
               iss_q.size(), (iss_q.size() > 0) ? iss_q[0] : -1);
    end
  endtask

  task automatic test_mask();
    test_program(0, 4'b0101, 3, -1, -1, -1);
    checks++;
    if (a_tp !== 32'h0003_0003) begin
      errors++;
      $display("FAIL mask_thread_pc: got %h required 00030003", a_tp);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    run_mask = 4'b1111; prog_len = 8'd5; start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (a_busy !== 1'b0 || a_done !== 1'b0 || a_valid !== 1'b0 || a_tp !== 32'h0) begin
        errors++;
        $display("FAIL reset_mid c%0d: busy=%b done=%b valid=%b tp=%h, required 0/0/0/0",
                 i, a_busy, a_done, a_valid, a_tp);
      end
    end
  endtask

  task automatic test_rr_pick();
    int exp_tid;
    bit fnd;
    for (int n = 0; n < 40; n++) begin
      rp_el = 4'($urandom_range(0, 15));
      rp_ptr = 2'($urandom_range(0, 3));
      fnd = 0; exp_tid = 0;
      for (int k = 0; k < 4; k++)
        if (!fnd && rp_el[(int'(rp_ptr) + k) % 4]) begin fnd = 1; exp_tid = (int'(rp_ptr) + k) % 4; end
      #1;
      checks++;
      if (rp_found !== fnd || (fnd && rp_tid !== exp_tid[1:0])) begin
        errors++;
        $display("FAIL rr_pick el=%b ptr=%0d: got found=%b tid=%0d required %b/%0d",
                 rp_el, rp_ptr, rp_found, rp_tid, fnd, exp_tid);
      end
    end
  endtask

  task automatic test_random();
    int lo;
    for (int n = 0; n < 8; n++) begin
      lo = $urandom_range(0, 8);
      test_program(n % 2, 4'($urandom_range(0, 15)), $urandom_range(0, 6),
                   lo, lo + $urandom_range(0, 3), -1);
    end
  endtask

  initial begin
    rp_el = '0; rp_ptr = '0;
    test_reset();
    test_rr_pick();
    test_basic();
    test_mask();
    test_program(1, 4'b0001, 3, -1, -1, -1);   // EXEC_LAT=3 spacing
    test_program(1, 4'b1011, 4, 1, 5, -1);
    test_program(0, 4'b1111, 3, 2, 4, -1);     // stall window
    test_program(0, 4'b1111, 0, -1, -1, -1);   // empty program
    test_program(0, 4'b0000, 3, -1, -1, -1);   // no threads
    test_program(0, 4'b1111, 4, -1, -1, 3);    // abort after 3rd issue
    test_program(0, 4'b1111, 2, -1, -1, -1);
    test_reset_mid();
    test_program(0, 4'b1111, 2, -1, -1, -1);
    test_program(0, 4'b0001, 255, -1, -1, -1); // maximum length, no wrap
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
